// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared fetch constants and prefetch queue entry type
package mips_pkg;

  localparam int          INST_W   = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [31:0]       pc4;
  } qentry_t;

endpackage

// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - DEPTH-entry prefetch FIFO with synchronous flush
module inst_queue
  import mips_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     clrn,
  input  logic                     push,
  input  qentry_t                  push_data,
  input  logic                     pop,
  input  logic                     flush,
  output qentry_t                  head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  qentry_t         mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  // Storage needs no reset; an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC, single-outstanding imem fetch, prefetch queue and IF/ID register
module fetch_stage #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC,
  parameter logic [31:0] NOP_INST = mips_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        clrn,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        id_stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_id_valid,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc4
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [31:0]       fetch_pc;
  logic [31:0]       req_pc4;
  logic              outstanding;
  logic              discard;

  mips_pkg::qentry_t q_head;
  mips_pkg::qentry_t q_in;
  logic [AW:0]       q_count;
  logic              q_empty;
  logic              q_full;
  logic              q_push;
  logic              q_pop;
  logic              req_fire;
  logic              rsp_take;

  assign imem_req_valid = clrn && !outstanding && (q_count < DEPTH_C) && !redirect;
  assign imem_req_addr  = fetch_pc;

  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_take = imem_rsp_valid && outstanding;
  assign q_in.inst = imem_rsp_data;
  assign q_in.pc4  = req_pc4;
  assign q_push   = rsp_take && !discard && !redirect && !q_full;
  assign q_pop    = !id_stall && !redirect && !q_empty;

  inst_queue #(.DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .clrn      (clrn),
    .push      (q_push),
    .push_data (q_in),
    .pop       (q_pop),
    .flush     (redirect),
    .head      (q_head),
    .count     (q_count),
    .empty     (q_empty),
    .full      (q_full)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      fetch_pc    <= RESET_PC;
      req_pc4     <= '0;
      outstanding <= 1'b0;
      discard     <= 1'b0;
    end else if (redirect) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      // A response landing in the redirect cycle is the stale one; nothing left to discard.
      if (rsp_take) begin
        outstanding <= 1'b0;
        discard     <= 1'b0;
      end else if (outstanding) begin
        discard <= 1'b1;
      end
    end else begin
      if (req_fire) begin
        fetch_pc    <= fetch_pc + 32'd4;
        req_pc4     <= fetch_pc + 32'd4;
        outstanding <= 1'b1;
      end
      if (rsp_take) begin
        outstanding <= 1'b0;
        discard     <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      if_id_valid <= 1'b0;
      if_id_inst  <= NOP_INST;
      if_id_pc4   <= '0;
    end else if (redirect) begin
      if_id_valid <= 1'b0;
      if_id_inst  <= NOP_INST;
    end else if (!id_stall) begin
      if (!q_empty) begin
        if_id_valid <= 1'b1;
        if_id_inst  <= q_head.inst;
        if_id_pc4   <= q_head.pc4;
      end else begin
        if_id_valid <= 1'b0;
        if_id_inst  <= NOP_INST;
      end
    end
  end

endmodule
